// File: rtl/dmem_store_buffer_pkg.sv
// Shared memory-subsystem definitions for the data-memory store buffer:
// default depth, entry field widths and the legal store/load size codes.
package dmem_store_buffer_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 64;
  localparam int SB_SIZE_W = 4;

  // Size field carries a plain byte count.
  typedef enum logic [SB_SIZE_W-1:0] {
    SB_SZ_B = 4'd1,
    SB_SZ_H = 4'd2,
    SB_SZ_W = 4'd4,
    SB_SZ_D = 4'd8
  } sb_size_e;

  // True for the byte counts the pipeline is allowed to issue.
  function automatic logic sb_size_legal(input logic [SB_SIZE_W-1:0] size);
    return (size == SB_SZ_B) || (size == SB_SZ_H) ||
           (size == SB_SZ_W) || (size == SB_SZ_D);
  endfunction

endpackage

// File: rtl/dmem_store_buffer_if.sv
// Bundle of all store-buffer signals: pipeline store port, data-memory write
// port, load-overlap query and occupancy status.
// slave  : the store buffer's view.
// master : the surrounding pipeline / memory subsystem view.
interface dmem_store_buffer_if
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int DADDRW = SB_ADDR_W,
  parameter int DDATAW = SB_DATA_W,
  parameter int DSIZEW = SB_SIZE_W
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic              st_valid;
  logic              st_ready;
  logic [DADDRW-1:0] st_address;
  logic [DDATAW-1:0] st_data;
  logic [DSIZEW-1:0] st_size;

  logic              dmem_w_valid;
  logic              dmem_w_ready;
  logic [DADDRW-1:0] dmem_w_address;
  logic              dmem_w_wr_en;
  logic [DDATAW-1:0] dmem_w_wr_data;
  logic [DSIZEW-1:0] dmem_w_wr_size;

  logic [DADDRW-1:0] ld_address;
  logic [DSIZEW-1:0] ld_size;
  logic              ld_conflict;

  logic              sb_empty;
  logic [CW-1:0]     sb_count;

  modport slave (
    input  st_valid, st_address, st_data, st_size,
    input  dmem_w_ready,
    input  ld_address, ld_size,
    output st_ready,
    output dmem_w_valid, dmem_w_address, dmem_w_wr_en, dmem_w_wr_data, dmem_w_wr_size,
    output ld_conflict, sb_empty, sb_count
  );

  modport master (
    output st_valid, st_address, st_data, st_size,
    output dmem_w_ready,
    output ld_address, ld_size,
    input  st_ready,
    input  dmem_w_valid, dmem_w_address, dmem_w_wr_en, dmem_w_wr_data, dmem_w_wr_size,
    input  ld_conflict, sb_empty, sb_count
  );

endinterface

// File: rtl/dmem_sb_overlap.sv
// Byte-range overlap comparator: [st_address, st_address+st_size) against
// [ld_address, ld_address+ld_size). Range ends are formed one bit wider than
// the address so a range touching the top of the address space never wraps.
module dmem_sb_overlap
  import dmem_store_buffer_pkg::*;
#(
  parameter int DADDRW = SB_ADDR_W,
  parameter int DSIZEW = SB_SIZE_W
) (
  input  logic [DADDRW-1:0] st_address,
  input  logic [DSIZEW-1:0] st_size,
  input  logic [DADDRW-1:0] ld_address,
  input  logic [DSIZEW-1:0] ld_size,
  output logic              hit
);

  localparam int EW = DADDRW + 1;

  logic [EW-1:0] st_lo, st_hi, ld_lo, ld_hi;

  // Half-open interval intersection; an empty range on either side never hits.
  always_comb begin
    st_lo = {1'b0, st_address};
    ld_lo = {1'b0, ld_address};
    st_hi = st_lo + EW'(st_size);
    ld_hi = ld_lo + EW'(ld_size);
    hit   = (st_size != '0) && (ld_size != '0) &&
            (st_lo < ld_hi) && (ld_lo < st_hi);
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// In-order store buffer between the memory/writeback stage and the
// data-memory write port. Circular FIFO of {address, data, size} with
// wrap-bit pointers; drains the head over a valid/ready handshake.
// Build option STORE_BUF_FWD_EN: precise per-entry load-overlap detection;
// without it any pending store flags every load as conflicting.
module dmem_store_buffer
  import dmem_store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int DADDRW = SB_ADDR_W,
  parameter int DDATAW = SB_DATA_W,
  parameter int DSIZEW = SB_SIZE_W
) (
  input logic               clk,
  input logic               reset,
  dmem_store_buffer_if.slave sb
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DADDRW-1:0] addr_q [DEPTH];
  logic [DDATAW-1:0] data_q [DEPTH];
  logic [DSIZEW-1:0] size_q [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic          empty, full, push, pop;

  // Occupancy and handshake qualification from the pointer pair.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    count = wr_ptr - rd_ptr;
    push  = sb.st_valid && !full;
    pop   = !empty && sb.dmem_w_ready;
  end

  // Pointers are the only reset state; clearing them discards every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Entry payload capture at the write slot; payload is never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr[AW-1:0]] <= sb.st_address;
      data_q[wr_ptr[AW-1:0]] <= sb.st_data;
      size_q[wr_ptr[AW-1:0]] <= sb.st_size;
    end
  end

  assign sb.st_ready      = !full;
  assign sb.dmem_w_valid  = !empty;
  assign sb.dmem_w_wr_en  = !empty;
  assign sb.dmem_w_address = addr_q[rd_ptr[AW-1:0]];
  assign sb.dmem_w_wr_data = data_q[rd_ptr[AW-1:0]];
  assign sb.dmem_w_wr_size = size_q[rd_ptr[AW-1:0]];
  assign sb.sb_empty      = empty;
  assign sb.sb_count      = count;

`ifdef STORE_BUF_FWD_EN
  logic [DEPTH-1:0] hit, live;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ovl
    dmem_sb_overlap #(
      .DADDRW (DADDRW),
      .DSIZEW (DSIZEW)
    ) u_ovl (
      .st_address (addr_q[i]),
      .st_size    (size_q[i]),
      .ld_address (sb.ld_address),
      .ld_size    (sb.ld_size),
      .hit        (hit[i])
    );
  end

  // A slot is live when its distance from the head is below the occupancy;
  // the head being popped this cycle is still live, a slot being written is not.
  always_comb begin
    logic [AW-1:0] off;
    off  = '0;
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off     = AW'(i) - rd_ptr[AW-1:0];
      live[i] = ({1'b0, off} < count);
    end
  end

  assign sb.ld_conflict = |(hit & live);
`else
  logic unused_ld;
  assign unused_ld      = ^{sb.ld_address, sb.ld_size};
  assign sb.ld_conflict = !empty;
`endif

endmodule
